rgb_led_scheduler: RTL
======================

// Module: rgb_led_scheduler
// PURPOSE
//   Time-shares the single on-board RGB LED between N_REQ requesters, such as status, heartbeat and error reporters.
//   Grants the LED round-robin with a minimum time slot per owner.
//   Generates three frame-aligned PWM streams from the current owner's duty values.
//   The PWM outputs and led_en drive the RGB0/1/2PWM and RGBLEDEN inputs of the SB_RGBA_DRV instance in the top level.
// PARAMETERS
//   N_REQ        4    number of requesters (2..8)
//   DUTY_W       8    duty / PWM phase width; one frame = 2**DUTY_W phase steps
//   PRESCALE     47   clk cycles per phase step minus 1 (48 MHz HFOSC -> 1 MHz step)
//   SLOT_FRAMES  64   minimum frames an owner keeps the LED while others wait
// PORTS
//   clk          in   1              single clock (int_osc)
//   rst          in   1              synchronous reset, active-high
//   req          in   N_REQ          level request per requester
//   duty         in   N_REQ*3*DUTY_W requester i at [i*3*DUTY_W +: 3*DUTY_W] = {r,g,b}
//   grant        out  N_REQ          one-hot current owner, 0 when idle
//   led_en       out  1              to RGBLEDEN, 1 while an owner is granted
//   pwm_r        out  1              red PWM
//   pwm_g        out  1              green PWM
//   pwm_b        out  1              blue PWM
//   frame_start  out  1              1-cycle pulse on the first clk of every frame
// BEHAVIOUR
//   Reset values
//   - All outputs 0. Prescaler 0, phase 0, slot_cnt 0, state IDLE.
//   - last_owner = N_REQ-1, so requester 0 wins the first arbitration.
//   Timebase
//   - tick when prescaler==PRESCALE; prescaler then wraps to 0.
//   - phase (DUTY_W bits) increments on tick and wraps.
//   - Frame boundary (fb) = tick && phase==all-ones.
//   - frame_start is registered from fb and is high in the cycle where phase becomes 0.
//   - The timebase free-runs in every state.
//   FSM: IDLE, OWN. Decisions are made only on fb cycles; all results register at that clk edge.
//   - IDLE, at fb:
//     - if |req: pick the first requesting index after last_owner (modulo N_REQ).
//     - Set owner = pick, grant = onehot(pick), last_owner = pick, slot_cnt = 0; go to OWN.
//   - OWN, at fb, rules evaluated in this order:
//     - (a) req[owner]==0: re-arbitrate as in IDLE, or go to IDLE with grant=0 if no req.
//     - (b) slot_cnt==SLOT_FRAMES-1 and another req is pending: rotate to the next requester after owner; slot_cnt = 0.
//     - (c) otherwise stay; slot_cnt increments and saturates at SLOT_FRAMES-1.
//   - A lone requester keeps the LED indefinitely.
//   Duty latch
//   - duty_q {r,g,b} loads the new owner's duty at every fb that results in OWN.
//   - Duty changes mid-frame have no effect until the next fb.
//   PWM generation
//   - pwm_x <= (state==OWN) & req[owner] & (phase < duty_q_x).
//   - Registered: one clk latency after phase.
//   - Duty 0 means always off; duty 2**DUTY_W-1 means on for all but one step per frame.
//   - Owner dropping req mid-frame blanks all PWM on the next clk.
//   - In that case grant stays asserted until the fb.
//   - led_en <= (state==OWN), updated at fb only.
//   Simultaneous events
//   - A req rising on an fb cycle is eligible in that same arbitration.
//   - Owner drop together with slot expiry is handled by (a).
//   - rst overrides everything: on the cycle after rst, all outputs are 0 and the FSM is in IDLE.
//   Arithmetic
//   - Comparison is unsigned DUTY_W bits; the round-robin index wraps modulo N_REQ.
// TESTING  (N_REQ=3, DUTY_W=4, PRESCALE=0, SLOT_FRAMES=2 -> 16-clk frames)
//   1. rst then req=0 for 100 clks -> grant=0, pwm_*=0, led_en=0; frame_start every 16 clks.
//   2. req=001, duty0={4,0,15} -> grant=001 from the first fb.
//      - Per frame: pwm_r high 4 clks, pwm_g 0, pwm_b high 15 clks; led_en=1.
//   3. req=011 held -> grant 001 for 2 frames, then 010 for 2 frames, then 001; the rotation repeats.
//   4. Owner drops req mid-frame while req1 is pending -> pwm_*=0 on the next clk.
//      - grant switches to 010 at the fb.
//      - If no other req is pending, grant=0 and led_en=0 at the fb.
//   5. duty0 changed 4->9 at phase 5 -> the current frame keeps duty 4; the next frame shows 9 high clks.
//   6. Assert rst for 1 clk while requester 2 owns the LED -> all outputs 0 on the next clk.
//      - With req=111 afterwards, requester 0 is granted at the first fb.

Source files
------------

// File: rtl/rgb_led_scheduler_if.sv
// rtl/rgb_led_scheduler_if.sv - request/duty in, grant/led_en/pwm/frame_start out for the rgb led scheduler
interface rgb_led_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int DUTY_W = 8
);
    logic [N_REQ-1:0]          req;          // level request per requester
    logic [N_REQ*3*DUTY_W-1:0] duty;         // requester i at [i*3*DUTY_W +: 3*DUTY_W] = {r,g,b}
    logic [N_REQ-1:0]          grant;        // one-hot current owner, 0 when idle
    logic                      led_en;       // 1 while an owner is granted
    logic                      pwm_r;
    logic                      pwm_g;
    logic                      pwm_b;
    logic                      frame_start;  // 1-cycle pulse on the first clk of every frame

    modport master (
        output req, duty,
        input  grant, led_en, pwm_r, pwm_g, pwm_b, frame_start
    );

    modport slave (
        input  req, duty,
        output grant, led_en, pwm_r, pwm_g, pwm_b, frame_start
    );
endinterface

// File: rtl/rgb_led_scheduler.sv
// rtl/rgb_led_scheduler.sv - round-robin time-sharing of one RGB LED with frame-aligned PWM
module rgb_led_scheduler #(
    parameter int N_REQ       = 4,
    parameter int DUTY_W      = 8,
    parameter int PRESCALE    = 47,
    parameter int SLOT_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    rgb_led_scheduler_if.slave   bus
);
    localparam int PS_W  = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam int SC_W  = (SLOT_FRAMES > 1) ? $clog2(SLOT_FRAMES) : 1;
    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(PRESCALE);
    localparam logic [SC_W-1:0] SLOT_LAST = SC_W'(SLOT_FRAMES - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t             state;
    logic [PS_W-1:0]    prescaler;
    logic [DUTY_W-1:0]  phase;
    logic [SC_W-1:0]    slot_cnt;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   last_owner;
    logic [DUTY_W-1:0]  duty_r;
    logic [DUTY_W-1:0]  duty_g;
    logic [DUTY_W-1:0]  duty_b;

    logic               tick;
    logic               fb;
    logic               req_owner;
    logic               others_pending;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;
    logic               rearb;
    logic               take_pick;
    logic               go_idle;
    logic [IDX_W-1:0]   sel_idx;
    logic [3*DUTY_W-1:0] duty_sel;

    assign tick           = (prescaler == PS_LAST);
    assign fb             = tick && (&phase);
    assign req_owner      = bus.req[owner];
    // In OWN the grant register is exactly onehot(owner), so this masks the owner out.
    assign others_pending = |(bus.req & ~bus.grant);

    // First requester after last_owner, wrapping modulo N_REQ. Walking the ring
    // backwards lets the nearest candidate overwrite the farther ones. In OWN,
    // last_owner equals owner, so the same search serves the slot rotation.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_owner) + k) % N_REQ);
            if (bus.req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    // Owner drop (or idle) takes priority over slot expiry.
    assign rearb     = (state == IDLE) || !req_owner;
    assign take_pick = fb && (rearb ? pick_valid : ((slot_cnt == SLOT_LAST) && others_pending));
    assign go_idle   = fb && rearb && !pick_valid;
    assign sel_idx   = take_pick ? pick : owner;
    assign duty_sel  = bus.duty[int'(sel_idx) * 3 * DUTY_W +: 3 * DUTY_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            prescaler       <= '0;
            phase           <= '0;
            slot_cnt        <= '0;
            owner           <= '0;
            last_owner      <= IDX_W'(N_REQ - 1);
            duty_r          <= '0;
            duty_g          <= '0;
            duty_b          <= '0;
            bus.grant       <= '0;
            bus.led_en      <= 1'b0;
            bus.pwm_r       <= 1'b0;
            bus.pwm_g       <= 1'b0;
            bus.pwm_b       <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            prescaler       <= tick ? '0 : prescaler + PS_W'(1);
            if (tick) begin
                phase <= phase + DUTY_W'(1);
            end
            bus.frame_start <= fb;

            // Live req[owner] here blanks the LED one clk after the owner lets go,
            // while grant holds until the frame boundary.
            bus.pwm_r <= (state == OWN) && req_owner && (phase < duty_r);
            bus.pwm_g <= (state == OWN) && req_owner && (phase < duty_g);
            bus.pwm_b <= (state == OWN) && req_owner && (phase < duty_b);

            if (go_idle) begin
                state      <= IDLE;
                bus.grant  <= '0;
                bus.led_en <= 1'b0;
            end else if (fb) begin
                if (take_pick) begin
                    owner      <= pick;
                    last_owner <= pick;
                    slot_cnt   <= '0;
                    bus.grant  <= N_REQ'(1) << pick;
                end else if (slot_cnt != SLOT_LAST) begin
                    slot_cnt <= slot_cnt + SC_W'(1);
                end
                state      <= OWN;
                bus.led_en <= 1'b1;
                duty_r     <= duty_sel[3*DUTY_W-1:2*DUTY_W];
                duty_g     <= duty_sel[2*DUTY_W-1:DUTY_W];
                duty_b     <= duty_sel[DUTY_W-1:0];
            end
        end
    end
endmodule
